// File: rtl/seq_alu_master_pkg.sv
// Shared types for the sequential-ALU request initiator: ALU opcodes and the
// default-width response record.
package seq_alu_master_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_AND = 2'd2,
      OP_OR  = 2'd3
   } opcode_e;

   localparam int RSP_DATA_W = 8;
   localparam int RSP_TAG_W  = 4;

   typedef struct packed {
      logic [RSP_DATA_W-1:0] data;
      logic [RSP_TAG_W-1:0]  tag;
   } seq_alu_rsp_t;

endpackage

// File: rtl/seq_alu_rsp_fifo.sv
// Show-ahead response FIFO: the head entry is visible on rdata while not empty.
// Storage is cleared on reset so the head reads zero until the first write.
module seq_alu_rsp_fifo #(
   parameter int W     = 12,
   parameter int DEPTH = 4
) (
   input  logic                     clk_sys,
   input  logic                     rst_b,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/seq_alu_master.sv
// Request-side initiator for the sequential ALU: issues one op per cycle,
// captures C one cycle later and returns in-order tagged results with credit back-pressure.
module seq_alu_master
   import seq_alu_master_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int TAG_W     = 4,
   parameter int RSP_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  opcode_e          req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             alu_en,
   output opcode_e          alu_opcode,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_c,
   output logic             busy
);

   localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

   logic                     accept;
   logic                     pop;
   logic [TAG_W-1:0]         s1_tag;
   logic                     cap_pending;
   logic [TAG_W-1:0]         cap_tag;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [CNT_W-1:0]         fifo_count;
   logic [WIDTH+TAG_W-1:0]   fifo_rdata;
   logic [CNT_W-1:0]         in_use;
   logic                     credit_avail;

   // Every op in the pipe already owns a FIFO slot, so the FIFO can never overflow.
   // A pop in the same cycle frees a slot, letting accept and pop overlap at the limit.
   assign in_use       = CNT_W'(alu_en) + CNT_W'(cap_pending) + fifo_count;
   assign credit_avail = (in_use < CNT_W'(RSP_DEPTH));
   assign pop          = rsp_valid && rsp_ready;
   assign req_ready    = rst && (credit_avail || pop);
   assign accept       = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_en     <= 1'b0;
         alu_opcode <= OP_ADD;
         alu_a      <= '0;
         alu_b      <= '0;
         s1_tag     <= '0;
      end else begin
         alu_en <= accept;
         if (accept) begin
            alu_opcode <= req_op;
            alu_a      <= req_a;
            alu_b      <= req_b;
            s1_tag     <= req_tag;
         end
      end
   end

   // The ALU updates C on the same edge that sets cap_pending.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_pending <= 1'b0;
         cap_tag     <= '0;
      end else begin
         cap_pending <= alu_en;
         if (alu_en) begin
            cap_tag <= s1_tag;
         end
      end
   end

   seq_alu_rsp_fifo #(
      .W     (WIDTH + TAG_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk_sys (clk),
      .rst_b   (rst),
      .push    (cap_pending),
      .wdata   ({alu_c, cap_tag}),
      .pop     (pop),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign rsp_valid           = !fifo_empty;
   assign {rsp_data, rsp_tag} = fifo_rdata;
   assign busy                = alu_en || cap_pending || !fifo_empty;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(fifo_full && cap_pending));

endmodule

// File: tb/tb_seq_alu_master.sv
// Scoreboard bench for seq_alu_master with a behavioural ALU attached to its issue port.
module tb_seq_alu_master;
   import seq_alu_master_pkg::*;

   localparam int WIDTH     = 8;
   localparam int TAG_W     = 4;
   localparam int RSP_DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   opcode_e          req_op = OP_ADD;
   logic [WIDTH-1:0] req_a = '0;
   logic [WIDTH-1:0] req_b = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [WIDTH-1:0] rsp_data;
   logic [TAG_W-1:0] rsp_tag;
   logic             alu_en;
   opcode_e          alu_opcode;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_c;
   logic             busy;

   typedef struct {
      seq_alu_rsp_t rsp;
      int           acc;
   } exp_t;

   int               checks = 0;
   int               failures = 0;
   int               cyc = 0;
   exp_t             exp_q[$];
   int               pop_log[$];
   bit               rand_bp = 1'b0;
   bit               stall_prev = 1'b0;
   logic [WIDTH-1:0] held_data = '0;
   logic [TAG_W-1:0] held_tag = '0;
   exp_t             mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // Stand-in for the sequential ALU: C updates on the edge after en is sampled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_c <= '0;
      end else if (alu_en) begin
         case (alu_opcode)
            OP_ADD:  alu_c <= alu_a + alu_b;
            OP_SUB:  alu_c <= alu_a - alu_b;
            OP_AND:  alu_c <= alu_a & alu_b;
            default: alu_c <= alu_a | alu_b;
         endcase
      end
   end

   seq_alu_master #(
      .WIDTH     (WIDTH),
      .TAG_W     (TAG_W),
      .RSP_DEPTH (RSP_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_tag    (req_tag),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_tag    (rsp_tag),
      .alu_en     (alu_en),
      .alu_opcode (alu_opcode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_c      (alu_c),
      .busy       (busy)
   );

   function automatic logic [WIDTH-1:0] ref_alu(opcode_e op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
      int r;
      case (op)
         OP_ADD:  r = int'(a) + int'(b);
         OP_SUB:  r = int'(a) - int'(b) + 256;
         OP_AND:  r = int'(a & b);
         default: r = int'(a | b);
      endcase
      return WIDTH'(r % 256);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(string pfx);
      check({pfx, "_alu_en"},     alu_en, 0);
      check({pfx, "_alu_opcode"}, alu_opcode, OP_ADD);
      check({pfx, "_alu_a"},      alu_a, 0);
      check({pfx, "_alu_b"},      alu_b, 0);
      check({pfx, "_rsp_valid"},  rsp_valid, 0);
      check({pfx, "_rsp_data"},   rsp_data, 0);
      check({pfx, "_rsp_tag"},    rsp_tag, 0);
      check({pfx, "_busy"},       busy, 0);
      check({pfx, "_req_ready"},  req_ready, 0);
   endtask

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic send(opcode_e op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                       logic [TAG_W-1:0] tag, output int waited);
      bit   rdy;
      exp_t e;
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
      waited    = 0;
      rdy       = 1'b0;
      forever begin
         @(negedge clk);
         rdy = req_ready;
         @(posedge clk);
         if (rdy || waited > 500) break;
         waited++;
      end
      #1;
      if (rdy) begin
         e.rsp.data = ref_alu(op, a, b);
         e.rsp.tag  = tag;
         e.acc      = cyc;
         exp_q.push_back(e);
      end else begin
         checks++;
         failures++;
         $display("FAIL req_timeout: request tag %0h not accepted after %0d cycles", tag, waited);
      end
      req_valid = 1'b0;
   endtask

   // Accept happened at edge number acc; FIFO must be empty beforehand.
   task automatic check_latency(string name, int acc);
      @(negedge clk);
      check({name, "_alu_en"}, alu_en, 1);
      check({name, "_cycle"}, cyc, acc);
      @(negedge clk);
      check({name, "_valid_early"}, rsp_valid, 0);
      @(negedge clk);
      check({name, "_valid_at_2"}, rsp_valid, 1);
      step();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d responses outstanding expected 0", exp_q.size());
      end
      step();
      step();
   endtask

   always @(posedge clk) begin
      if (rand_bp) begin
         #1;
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: transfers are decided at the negedge before the edge that performs them.
   always @(negedge clk) begin
      if (!rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", rsp_valid, 1);
            check("stall_data", rsp_data, held_data);
            check("stall_tag", rsp_tag, held_tag);
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rsp: got data %0h tag %0h expected no response", rsp_data, rsp_tag);
            end else begin
               mon_e = exp_q.pop_front();
               check("rsp_data", rsp_data, mon_e.rsp.data);
               check("rsp_tag", rsp_tag, mon_e.rsp.tag);
               check("rsp_latency_ge2", (cyc - mon_e.acc) >= 2, 1);
               pop_log.push_back(cyc);
            end
         end
         stall_prev = rsp_valid && !rsp_ready;
         held_data  = rsp_data;
         held_tag   = rsp_tag;
      end
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int   w;
      int   acc;
      bit   rdy;
      exp_t e;

      #3;
      check_reset_values("reset");
      step();
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_reset", req_ready, 1);
      step();
      rsp_ready = 1'b1;

      // ADD with exact latency
      send(OP_ADD, 8'h0F, 8'h01, 4'd3, w);
      acc = cyc;
      check_latency("add", acc);
      drain();

      // SUB and ADD wrap-around
      send(OP_SUB, 8'h00, 8'h01, 4'd5, w);
      send(OP_ADD, 8'hFF, 8'h01, 4'd6, w);
      drain();

      // back-to-back mixed ops
      pop_log.delete();
      send(OP_AND, 8'hF0, 8'h3C, 4'd0, w); check("b2b_ready0", w, 0);
      send(OP_OR,  8'hF0, 8'h0F, 4'd1, w); check("b2b_ready1", w, 0);
      send(OP_ADD, 8'h02, 8'h03, 4'd2, w); check("b2b_ready2", w, 0);
      send(OP_SUB, 8'h09, 8'h04, 4'd3, w); check("b2b_ready3", w, 0);
      drain();
      check("b2b_count", pop_log.size(), 4);
      if (pop_log.size() == 4) begin
         for (int i = 1; i < 4; i++) begin
            check("b2b_consecutive", pop_log[i] - pop_log[i-1], 1);
         end
      end

      // back-pressure: four credits, then stall until a pop
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(OP_ADD, WIDTH'(i * 16), WIDTH'(i + 1), TAG_W'(i + 8), w);
         check("bp_accept", w, 0);
      end
      req_valid = 1'b1;
      req_op    = OP_SUB;
      req_a     = 8'h50;
      req_b     = 8'h10;
      req_tag   = 4'hC;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_ready_low", req_ready, 0);
         check("bp_busy", busy, 1);
         step();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rdy = req_ready;
      check("bp_ready_return", rdy, 1);
      step();
      if (rdy) begin
         e.rsp.data = ref_alu(OP_SUB, 8'h50, 8'h10);
         e.rsp.tag  = 4'hC;
         e.acc      = cyc;
         exp_q.push_back(e);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      step();
      step();
      rsp_ready = 1'b1;
      drain();

      // reset with three buffered and one in flight
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(OP_OR, WIDTH'($urandom), WIDTH'($urandom), TAG_W'(i), w);
      end
      step();
      #2;
      rst = 1'b0;
      exp_q.delete();
      #1;
      check_reset_values("midrst");
      @(negedge clk);
      #2;
      rst = 1'b1;
      @(negedge clk);
      check("post_reset_busy", busy, 0);
      check("post_reset_valid", rsp_valid, 0);
      check("post_reset_ready", req_ready, 1);
      rsp_ready = 1'b1;
      repeat (3) step();
      send(OP_ADD, 8'h01, 8'h01, 4'd7, w);
      acc = cyc;
      check_latency("rst_add", acc);
      drain();

      // randomized traffic with random consumer stalls
      rand_bp = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send(opcode_e'($urandom_range(0, 3)), WIDTH'($urandom), WIDTH'($urandom), TAG_W'($urandom), w);
         if ($urandom_range(0, 3) == 0) step();
      end
      rand_bp = 1'b0;
      @(posedge clk);
      #2;
      rsp_ready = 1'b1;
      drain();
      check("final_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
